// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared sizes and master-ID encoding for the on-chip memory arbiter slice.
package onchip_mem_arbiter_pkg;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int NUM_WORDS = 5120;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the history register lives in the parent.
module rr_arb2
  import onchip_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last,
  input  logic       en,
  output logic [1:0] gnt,
  output master_id_t gnt_id
);

  // On contention the master that did not win most recently goes next.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = M0;
    if (en) begin
      case (req)
        2'b01: begin
          gnt    = 2'b01;
          gnt_id = M0;
        end
        2'b10: begin
          gnt    = 2'b10;
          gnt_id = M1;
        end
        2'b11: begin
          if (last == M0) begin
            gnt    = 2'b10;
            gnt_id = M1;
          end else begin
            gnt    = 2'b01;
            gnt_id = M0;
          end
        end
        default: begin
          gnt    = 2'b00;
          gnt_id = M0;
        end
      endcase
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters, one access per cycle.
module onchip_mem_arbiter
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = onchip_mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W    = onchip_mem_arbiter_pkg::DATA_W,
  parameter int BE_W      = onchip_mem_arbiter_pkg::BE_W,
  parameter int NUM_WORDS = onchip_mem_arbiter_pkg::NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              range_err
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_WORDS);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        en;
  logic        granted;
  logic        sel_write;
  logic        sel_oor;
  master_id_t  gnt_id;
  master_id_t  last;
  logic        rv_valid;
  master_id_t  rv_id;
  logic        rv_oor;

  assign req     = {m1_read | m1_write, m0_read | m0_write};
  assign en      = ~reset & ~freeze;
  assign granted = |gnt;

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .last   (last),
    .en     (en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign mem_address    = (gnt_id == M1) ? m1_address    : m0_address;
  assign mem_byteenable = (gnt_id == M1) ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = (gnt_id == M1) ? m1_writedata  : m0_writedata;
  assign sel_write      = (gnt_id == M1) ? m1_write      : m0_write;
  assign sel_oor        = (mem_address >= ADDR_LIMIT);

  // Out-of-range grants are still accepted, but never reach the RAM.
  assign mem_chipselect = granted & ~sel_oor;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_clken      = ~freeze;

  assign m0_waitrequest = ~en | (req[0] & ~gnt[0]);
  assign m1_waitrequest = ~en | (req[1] & ~gnt[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= M1;
      rv_valid  <= 1'b0;
      rv_id     <= M0;
      rv_oor    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      rv_valid <= granted & ~sel_write;
      rv_id    <= gnt_id;
      rv_oor   <= sel_oor;
      if (granted) begin
        last <= gnt_id;
      end
      if (granted && sel_oor) begin
        range_err <= 1'b1;
      end
    end
  end

  // Reset in the return cycle kills a read already in flight.
  assign m0_readdatavalid = rv_valid & ~reset & (rv_id == M0);
  assign m1_readdatavalid = rv_valid & ~reset & (rv_id == M1);
  assign m0_readdata = (rv_valid && rv_id == M0 && !rv_oor) ? mem_readdata : '0;
  assign m1_readdata = (rv_valid && rv_id == M1 && !rv_oor) ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench with a behavioural RAM and a per-master read-data scoreboard.
module tb_onchip_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        freeze;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;
  logic        range_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  logic [31:0] ram [0:8191];
  logic [31:0] ram_q;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .freeze           (freeze),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .range_err        (range_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with byte lanes, one-cycle q, q held while clken is low.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic required);
    checkOutput(name, {31'b0, actual}, {31'b0, required});
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [12:0] a0,
                               input logic [3:0] be0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [12:0] a1,
                               input logic [3:0] be1, input logic [31:0] d1, input logic frz);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    freeze = frz;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic bothRead(input logic frz);
    applyStimulus(1'b1, 1'b0, 13'd1, 4'hF, 32'h0, 1'b1, 1'b0, 13'd2, 4'hF, 32'h0, frz);
  endtask

  task automatic atNeg();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every readdatavalid pops the expected word for that master.
  always @(negedge clk) begin
    if (m0_readdatavalid !== 1'b0) begin
      if (q0.size() == 0) checkBit("m0_readdatavalid unexpected", m0_readdatavalid, 1'b0);
      else begin
        checkOutput("m0_readdata", m0_readdata, q0.pop_front());
        checkOutput("m1_readdata while m0 returns", m1_readdata, 32'h0);
      end
    end
    if (m1_readdatavalid !== 1'b0) begin
      if (q1.size() == 0) checkBit("m1_readdatavalid unexpected", m1_readdatavalid, 1'b0);
      else begin
        checkOutput("m1_readdata", m1_readdata, q1.pop_front());
        checkOutput("m0_readdata while m1 returns", m0_readdata, 32'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    ram_q = 32'h0;
    reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state with a pending request.
    applyStimulus(1'b1, 1'b0, 13'd1, 4'hF, 32'h0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
    atNeg();
    checkBit("reset m0_waitrequest", m0_waitrequest, 1'b1);
    checkBit("reset m1_waitrequest", m1_waitrequest, 1'b1);
    checkBit("reset mem_chipselect", mem_chipselect, 1'b0);
    checkBit("reset mem_write", mem_write, 1'b0);
    checkBit("reset range_err", range_err, 1'b0);
    nextCycle();
    reset = 1'b0;

    // m0 write then m1 read of the same word.
    applyStimulus(1'b0, 1'b1, 13'd5, 4'hF, 32'h12345678, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
    atNeg();
    checkBit("t1 m0_waitrequest", m0_waitrequest, 1'b0);
    checkBit("t1 mem_chipselect", mem_chipselect, 1'b1);
    checkBit("t1 mem_write", mem_write, 1'b1);
    checkBit("t1 mem_clken", mem_clken, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0, 1'b0);
    q1.push_back(32'h12345678);
    atNeg();
    checkBit("t1 m1_waitrequest", m1_waitrequest, 1'b0);
    checkBit("t1 read mem_write", mem_write, 1'b0);
    nextCycle();
    idleInputs();
    nextCycle();

    // Seed addr 1 and 2 under contention: last=M1, so m0 wins first.
    applyStimulus(1'b0, 1'b1, 13'd1, 4'hF, 32'h11111111, 1'b0, 1'b1, 13'd2, 4'hF, 32'h22222222, 1'b0);
    atNeg();
    checkBit("seed m0_waitrequest", m0_waitrequest, 1'b0);
    checkBit("seed m1_waitrequest", m1_waitrequest, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0, 1'b1, 13'd2, 4'hF, 32'h22222222, 1'b0);
    atNeg();
    checkBit("seed m1 held waitrequest", m1_waitrequest, 1'b0);
    nextCycle();

    // Continuous read contention alternates m0, m1, m0, m1.
    for (int i = 0; i < 4; i++) begin
      bothRead(1'b0);
      if (i % 2 == 0) q0.push_back(32'h11111111);
      else            q1.push_back(32'h22222222);
      atNeg();
      checkBit("rr m0_waitrequest", m0_waitrequest, (i % 2) == 1);
      checkBit("rr m1_waitrequest", m1_waitrequest, (i % 2) == 0);
      nextCycle();
    end
    idleInputs();
    nextCycle();

    // Partial byte-lane write over zero.
    applyStimulus(1'b0, 1'b1, 13'd7, 4'b0010, 32'hAABBCCDD, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
    atNeg();
    checkOutput("t3 mem_byteenable", {28'h0, mem_byteenable}, 32'h2);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 13'd7, 4'hF, 32'h0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
    q0.push_back(32'h0000CC00);
    nextCycle();
    idleInputs();
    nextCycle();

    // Out-of-range write and read by m1; RAM q still holds 0x0000CC00.
    applyStimulus(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0, 1'b1, 13'd5200, 4'hF, 32'hDEADBEEF, 1'b0);
    atNeg();
    checkBit("oor wr m1_waitrequest", m1_waitrequest, 1'b0);
    checkBit("oor wr mem_chipselect", mem_chipselect, 1'b0);
    checkBit("oor wr mem_write", mem_write, 1'b0);
    checkBit("oor range_err before edge", range_err, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b1, 1'b0, 13'd5200, 4'hF, 32'h0, 1'b0);
    q1.push_back(32'h0);
    atNeg();
    checkBit("oor rd m1_waitrequest", m1_waitrequest, 1'b0);
    checkBit("oor rd mem_chipselect", mem_chipselect, 1'b0);
    checkBit("oor range_err set", range_err, 1'b1);
    nextCycle();
    idleInputs();
    atNeg();
    checkBit("oor range_err sticky", range_err, 1'b1);
    checkOutput("oor ram[5200] untouched", ram[5200], 32'h0);
    nextCycle();

    // Freeze for 3 cycles during contention; m0 read accepted just before.
    bothRead(1'b0);
    q0.push_back(32'h11111111);
    atNeg();
    checkBit("frz pre m0_waitrequest", m0_waitrequest, 1'b0);
    checkBit("frz pre m1_waitrequest", m1_waitrequest, 1'b1);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      bothRead(1'b1);
      atNeg();
      checkBit("frz m0_waitrequest", m0_waitrequest, 1'b1);
      checkBit("frz m1_waitrequest", m1_waitrequest, 1'b1);
      checkBit("frz mem_clken", mem_clken, 1'b0);
      checkBit("frz mem_chipselect", mem_chipselect, 1'b0);
      nextCycle();
    end
    bothRead(1'b0);
    q1.push_back(32'h22222222);
    atNeg();
    checkBit("frz post m1_waitrequest", m1_waitrequest, 1'b0);
    checkBit("frz post m0_waitrequest", m0_waitrequest, 1'b1);
    checkBit("frz post mem_clken", mem_clken, 1'b1);
    nextCycle();
    bothRead(1'b0);
    q0.push_back(32'h11111111);
    atNeg();
    checkBit("frz post2 m0_waitrequest", m0_waitrequest, 1'b0);
    nextCycle();
    idleInputs();
    nextCycle();

    // m0 read accepted, then reset: read lost, last returns to M1.
    applyStimulus(1'b1, 1'b0, 13'd1, 4'hF, 32'h0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
    atNeg();
    checkBit("rst pre m0_waitrequest", m0_waitrequest, 1'b0);
    nextCycle();
    reset = 1'b1;
    idleInputs();
    atNeg();
    checkBit("rst m0_readdatavalid suppressed", m0_readdatavalid, 1'b0);
    checkBit("rst m0_waitrequest", m0_waitrequest, 1'b1);
    checkBit("rst m1_waitrequest", m1_waitrequest, 1'b1);
    nextCycle();
    reset = 1'b0;
    bothRead(1'b0);
    q0.push_back(32'h11111111);
    atNeg();
    checkBit("post-rst m0 wins", m0_waitrequest, 1'b0);
    checkBit("post-rst m1 waits", m1_waitrequest, 1'b1);
    checkBit("post-rst range_err cleared", range_err, 1'b0);
    nextCycle();
    bothRead(1'b0);
    q1.push_back(32'h22222222);
    atNeg();
    checkBit("post-rst m1 wins", m1_waitrequest, 1'b0);
    nextCycle();
    idleInputs();
    repeat (2) nextCycle();

    checkOutput("m0 expected reads drained", q0.size(), 32'h0);
    checkOutput("m1 expected reads drained", q1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master round-robin arbiter that shares the single-port 32-bit on-chip memory (5120 words, 13-bit word address, byte enables, one-cycle read latency) between the Nios data master and a secondary DMA/accelerator master. It sits between the two Avalon-MM masters and the memory's s1 port. It grants at most one access per cycle, returns read data with fixed latency and readdatavalid, drops out-of-range accesses, and honours freeze.

## Interface
- ADDR_W, 13, word address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- NUM_WORDS, 5120, implemented depth; addresses >= NUM_WORDS are out of range
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- freeze  in  1  stall: no new grants while high
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid strobe
- mem_address  out  ADDR_W; mem_byteenable  out  BE_W; mem_writedata  out  DATA_W
- mem_chipselect  out  1; mem_write  out  1; mem_clken  out  1
- mem_readdata  in  DATA_W  memory q (valid the cycle after address capture)
- range_err  out  1  sticky: an out-of-range access occurred; cleared only by reset

## Operation
- Request mN_req = mN_read | mN_write. Read and write both high: treated as write.
- Arbitration (combinational, same cycle): only one requester -> it wins; both -> winner is the master not granted last; `last` register updated on every grant.
- Grant is suppressed when reset or freeze is high; both waitrequests are then high.
- Winner: waitrequest low, its address/byteenable/writedata muxed to mem_*. mem_chipselect = 1 on any in-range grant. mem_write = granted write. Loser: waitrequest high and must hold its request.
- Idle requester with no request: waitrequest low (Avalon idle convention is don't-care; the bench must not check it).
- Out-of-range grant (address >= NUM_WORDS): accepted (waitrequest low), mem_chipselect 0, write dropped, read returns 0 with normal latency, range_err set.
- Read return: pipeline regs rv_valid, rv_id, rv_oor captured on the grant edge. Next cycle, readdatavalid pulses for master rv_id only. readdata = rv_oor ? 0 : mem_readdata. The non-target readdata is driven 0.
- mem_clken = ~freeze. Freeze in the return cycle does not cancel the pending readdatavalid; q holds while clken is low.
- Back-to-back grants allowed every cycle. A read may immediately follow a write to the same address; read-during-write behaviour is the memory's (DONT_CARE), so the bench must not check it.

## Timing
- Reset values: last = 1 (m0 wins first contest); rv_valid = 0; range_err = 0; readdatavalid 0; while reset is high, both waitrequest high, mem_chipselect 0, mem_write 0.
- Write: accepted cycle N, memory updated at edge ending N.
- Read: accepted cycle N, readdatavalid and readdata in cycle N+1 exactly.
- Reset asserted at cycle N+1 with a read accepted in N: readdatavalid is suppressed; the read is lost.
- Throughput: one access per cycle total; under continuous contention each master gets every other cycle.
- No combinational path from mem_readdata to any waitrequest.

## Structure
- Shared package/include: ADDR_W, DATA_W, BE_W, NUM_WORDS defaults and the master-ID encoding (M0 = 0, M1 = 1).
- One sub-module: rr_arb2. Inputs are req[1:0], last and en; outputs are gnt[1:0] one-hot and gnt_id. It is purely combinational. The `last` register lives in the parent.

## Test plan
- Reset release, then m0 writes 0x12345678 to addr 5, be=4'hF, and m1 idle -> m0_waitrequest low for 1 cycle; a later m1 read of addr 5 gets readdatavalid 1 cycle after grant with 0x12345678.
- Both masters read continuously (m0 addr 1, m1 addr 2) after reset -> grants alternate m0, m1, m0, …; each readdatavalid lands on the correct master one cycle after its grant.
- m0 writes be=4'b0010 data 0xAABBCCDD over 0x00000000 at addr 7, then reads -> returns 0x0000CC00.
- m1 writes addr 5200 then reads addr 5200 -> mem_chipselect stays 0; read returns 0x00000000 with readdatavalid; range_err = 1 until reset.
- freeze high for 3 cycles during contention -> both waitrequest high, mem_clken 0; a read accepted the cycle before freeze still returns its data; arbitration resumes with the correct rotation.
- Reset pulsed the cycle after an accepted read -> no readdatavalid; last = 1 so m0 wins the next contest.
